lms_coeff_update: RTL and testbench

//  Complex LMS adaptation engine that produces firCoefficient_I/Q[TAPS] for the adaptive FIR.
//  Per sample strobe: forms error e = desired - filtered, shifts reference history,

---
 rtl/anc_pkg.sv | 30 +++
 rtl/lms_tap_mac.sv | 46 ++++
 rtl/lms_coeff_update.sv | 198 +++++++++++++++++++
 tb/tb_lms_coeff_update.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/anc_pkg.sv
// Shared types and arithmetic helpers for the adaptive noise canceller LMS engine.
// Holds the adaptation FSM encoding, width derivations and the saturating clamp.
package anc_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    UPDATE = 2'd1,
    COMMIT = 2'd2
  } lms_state_t;

  function automatic int acc_width(input int dbs, input int frac_bits);
    return dbs + frac_bits;
  endfunction

  // Complex product x*conj(e): each real product needs 2*dbs bits, the sum one more.
  function automatic int prod_width(input int dbs);
    return 2 * dbs + 1;
  endfunction

  function automatic logic signed [63:0] sat(input logic signed [63:0] value, input int width);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (width - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (width - 1));
    if (value > hi) return hi;
    if (value < lo) return lo;
    return value;
  endfunction

endpackage

// File: rtl/lms_tap_mac.sv
// Combinational complex LMS tap update: acc + (x * conj(e)) >>> MU_SHIFT, saturated.
// A single instance is time-shared across all taps by the adaptation FSM.
module lms_tap_mac
  import anc_pkg::*;
#(
  parameter int DATA_BUS_SIZE = 11,
  parameter int MU_SHIFT      = 10,
  parameter int FRAC_BITS     = 8,
  localparam int ACC_W        = DATA_BUS_SIZE + FRAC_BITS
) (
  input  logic signed [DATA_BUS_SIZE-1:0] x_re_i,
  input  logic signed [DATA_BUS_SIZE-1:0] x_im_i,
  input  logic signed [DATA_BUS_SIZE-1:0] e_re_i,
  input  logic signed [DATA_BUS_SIZE-1:0] e_im_i,
  input  logic signed [ACC_W-1:0]         acc_re_i,
  input  logic signed [ACC_W-1:0]         acc_im_i,
  output logic signed [ACC_W-1:0]         acc_re_o,
  output logic signed [ACC_W-1:0]         acc_im_o
);

  localparam int PROD_W = prod_width(DATA_BUS_SIZE);
  localparam int SUM_W  = ((ACC_W > PROD_W) ? ACC_W : PROD_W) + 1;

  logic signed [PROD_W-1:0] xr_w, xi_w, er_w, ei_w;
  logic signed [PROD_W-1:0] p_re, p_im, d_re, d_im;
  logic signed [SUM_W-1:0]  sum_re, sum_im;

  assign xr_w = PROD_W'(x_re_i);
  assign xi_w = PROD_W'(x_im_i);
  assign er_w = PROD_W'(e_re_i);
  assign ei_w = PROD_W'(e_im_i);

  // Multiplying by conj(e) flips the sign of the eQ cross terms.
  assign p_re = xr_w * er_w + xi_w * ei_w;
  assign p_im = xi_w * er_w - xr_w * ei_w;

  assign d_re = p_re >>> MU_SHIFT;
  assign d_im = p_im >>> MU_SHIFT;

  assign sum_re = SUM_W'(acc_re_i) + SUM_W'(d_re);
  assign sum_im = SUM_W'(acc_im_i) + SUM_W'(d_im);

  assign acc_re_o = ACC_W'(sat(64'(sum_re), ACC_W));
  assign acc_im_o = ACC_W'(sat(64'(sum_im), ACC_W));

endmodule

// File: rtl/lms_coeff_update.sv
// Complex LMS coefficient engine: latches the error on each sample strobe, then updates
// one tap per cycle and commits the whole coefficient set to the FIR in a single cycle.
module lms_coeff_update
  import anc_pkg::*;
#(
  parameter int DATA_BUS_SIZE = 11,
  parameter int TAPS          = 3,
  parameter int MU_SHIFT      = 10,
  parameter int FRAC_BITS     = 8
) (
  input  logic                                  clock,
  input  logic                                  reset,
  input  logic                                  sigEnable,
  input  logic                                  adaptEnable,
  input  logic                                  coefClear,
  input  logic signed [DATA_BUS_SIZE-1:0]       signal_I,
  input  logic signed [DATA_BUS_SIZE-1:0]       signal_Q,
  input  logic signed [DATA_BUS_SIZE-1:0]       desired_I,
  input  logic signed [DATA_BUS_SIZE-1:0]       desired_Q,
  input  logic signed [DATA_BUS_SIZE-1:0]       filtered_I,
  input  logic signed [DATA_BUS_SIZE-1:0]       filtered_Q,
  output logic [TAPS-1:0][DATA_BUS_SIZE-1:0]    firCoefficient_I,
  output logic [TAPS-1:0][DATA_BUS_SIZE-1:0]    firCoefficient_Q,
  output logic signed [DATA_BUS_SIZE-1:0]       error_I,
  output logic signed [DATA_BUS_SIZE-1:0]       error_Q,
  output logic                                  busy,
  output logic                                  update_done,
  output logic                                  overrun
);

  localparam int DBS   = DATA_BUS_SIZE;
  localparam int ACC_W = acc_width(DBS, FRAC_BITS);
  localparam int KW    = $clog2(TAPS);
  localparam logic [KW-1:0] K_LAST = KW'(TAPS - 1);

  lms_state_t state_q, state_d;
  logic [KW-1:0] k_q, k_d;
  logic signed [DBS-1:0] err_re_q, err_re_d, err_im_q, err_im_d;
  logic signed [DBS-1:0] xr_q [TAPS];
  logic signed [DBS-1:0] xr_d [TAPS];
  logic signed [DBS-1:0] xi_q [TAPS];
  logic signed [DBS-1:0] xi_d [TAPS];
  logic signed [ACC_W-1:0] accr_q [TAPS];
  logic signed [ACC_W-1:0] accr_d [TAPS];
  logic signed [ACC_W-1:0] acci_q [TAPS];
  logic signed [ACC_W-1:0] acci_d [TAPS];
  logic signed [DBS-1:0] coefr_q [TAPS];
  logic signed [DBS-1:0] coefr_d [TAPS];
  logic signed [DBS-1:0] coefi_q [TAPS];
  logic signed [DBS-1:0] coefi_d [TAPS];
  logic overrun_q, overrun_d;

  logic signed [DBS:0]     diff_re, diff_im;
  logic signed [DBS-1:0]   mac_xr, mac_xi;
  logic signed [ACC_W-1:0] mac_accr, mac_acci, mac_newr, mac_newi;

  assign diff_re = (DBS+1)'(desired_I) - (DBS+1)'(filtered_I);
  assign diff_im = (DBS+1)'(desired_Q) - (DBS+1)'(filtered_Q);

  // Tap k pairs with x[n-(TAPS-1-k)], so the last tap sees the newest sample.
  always_comb begin
    mac_xr   = '0;
    mac_xi   = '0;
    mac_accr = '0;
    mac_acci = '0;
    for (int k = 0; k < TAPS; k++) begin
      if (k_q == KW'(k)) begin
        mac_xr   = xr_q[TAPS-1-k];
        mac_xi   = xi_q[TAPS-1-k];
        mac_accr = accr_q[k];
        mac_acci = acci_q[k];
      end
    end
  end

  lms_tap_mac #(
    .DATA_BUS_SIZE(DBS),
    .MU_SHIFT     (MU_SHIFT),
    .FRAC_BITS    (FRAC_BITS)
  ) u_mac (
    .x_re_i  (mac_xr),
    .x_im_i  (mac_xi),
    .e_re_i  (err_re_q),
    .e_im_i  (err_im_q),
    .acc_re_i(mac_accr),
    .acc_im_i(mac_acci),
    .acc_re_o(mac_newr),
    .acc_im_o(mac_newi)
  );

  always_comb begin
    state_d   = state_q;
    k_d       = k_q;
    err_re_d  = err_re_q;
    err_im_d  = err_im_q;
    xr_d      = xr_q;
    xi_d      = xi_q;
    accr_d    = accr_q;
    acci_d    = acci_q;
    coefr_d   = coefr_q;
    coefi_d   = coefi_q;
    overrun_d = overrun_q;
    if (coefClear) begin
      state_d   = IDLE;
      k_d       = '0;
      overrun_d = 1'b0;
      for (int k = 0; k < TAPS; k++) begin
        accr_d[k]  = '0;
        acci_d[k]  = '0;
        coefr_d[k] = '0;
        coefi_d[k] = '0;
      end
    end else begin
      case (state_q)
        IDLE: begin
          if (sigEnable) begin
            err_re_d = DBS'(sat(64'(diff_re), DBS));
            err_im_d = DBS'(sat(64'(diff_im), DBS));
            xr_d[0]  = signal_I;
            xi_d[0]  = signal_Q;
            for (int j = 1; j < TAPS; j++) begin
              xr_d[j] = xr_q[j-1];
              xi_d[j] = xi_q[j-1];
            end
            if (adaptEnable) begin
              state_d = UPDATE;
              k_d     = '0;
            end
          end
        end
        UPDATE: begin
          for (int k = 0; k < TAPS; k++) begin
            if (k_q == KW'(k)) begin
              accr_d[k] = mac_newr;
              acci_d[k] = mac_newi;
            end
          end
          if (k_q == K_LAST) state_d = COMMIT;
          else k_d = k_q + 1'b1;
          if (sigEnable) overrun_d = 1'b1;
        end
        COMMIT: begin
          for (int k = 0; k < TAPS; k++) begin
            coefr_d[k] = accr_q[k][ACC_W-1 -: DBS];
            coefi_d[k] = acci_q[k][ACC_W-1 -: DBS];
          end
          state_d = IDLE;
          if (sigEnable) overrun_d = 1'b1;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      k_q       <= '0;
      err_re_q  <= '0;
      err_im_q  <= '0;
      overrun_q <= 1'b0;
      for (int k = 0; k < TAPS; k++) begin
        xr_q[k]    <= '0;
        xi_q[k]    <= '0;
        accr_q[k]  <= '0;
        acci_q[k]  <= '0;
        coefr_q[k] <= '0;
        coefi_q[k] <= '0;
      end
    end else begin
      state_q   <= state_d;
      k_q       <= k_d;
      err_re_q  <= err_re_d;
      err_im_q  <= err_im_d;
      overrun_q <= overrun_d;
      xr_q      <= xr_d;
      xi_q      <= xi_d;
      accr_q    <= accr_d;
      acci_q    <= acci_d;
      coefr_q   <= coefr_d;
      coefi_q   <= coefi_d;
    end
  end

  always_comb begin
    for (int k = 0; k < TAPS; k++) begin
      firCoefficient_I[k] = coefr_q[k];
      firCoefficient_Q[k] = coefi_q[k];
    end
  end

  assign error_I     = err_re_q;
  assign error_Q     = err_im_q;
  assign busy        = (state_q != IDLE);
  assign update_done = (state_q == COMMIT) && !coefClear;
  assign overrun     = overrun_q;

endmodule

// File: tb/tb_lms_coeff_update.sv
// Directed bench for lms_coeff_update with MU_SHIFT=2, FRAC_BITS=0, TAPS=3, 11-bit data.
// Each scenario task drives vectors and compares against hand-computed values.
module tb_lms_coeff_update;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic sigEnable = 1'b0, adaptEnable = 1'b0, coefClear = 1'b0;
  logic signed [10:0] signal_I = '0, signal_Q = '0;
  logic signed [10:0] desired_I = '0, desired_Q = '0;
  logic signed [10:0] filtered_I = '0, filtered_Q = '0;
  logic [2:0][10:0] firCoefficient_I, firCoefficient_Q;
  logic signed [10:0] error_I, error_Q;
  logic busy, update_done, overrun;

  int total = 0;
  int bad   = 0;

  always #5 clock = ~clock;

  lms_coeff_update #(
    .DATA_BUS_SIZE(11),
    .TAPS         (3),
    .MU_SHIFT     (2),
    .FRAC_BITS    (0)
  ) dut (
    .clock           (clock),
    .reset           (reset),
    .sigEnable       (sigEnable),
    .adaptEnable     (adaptEnable),
    .coefClear       (coefClear),
    .signal_I        (signal_I),
    .signal_Q        (signal_Q),
    .desired_I       (desired_I),
    .desired_Q       (desired_Q),
    .filtered_I      (filtered_I),
    .filtered_Q      (filtered_Q),
    .firCoefficient_I(firCoefficient_I),
    .firCoefficient_Q(firCoefficient_Q),
    .error_I         (error_I),
    .error_Q         (error_Q),
    .busy            (busy),
    .update_done     (update_done),
    .overrun         (overrun)
  );

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    int ci, cq;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    total++;
    if ({error_I, error_Q, busy, update_done, overrun} !== '0) begin
      bad++;
      $display("FAIL reset_state err=(%0d,%0d) busy=%b done=%b ovr=%b expected all 0",
               error_I, error_Q, busy, update_done, overrun);
    end
    signal_I = 11'sd100; desired_I = 11'sd40; sigEnable = 1'b1; adaptEnable = 1'b1;
    step();                       // cycle 1, strobe still high -> overrun
    step();                       // cycle 2
    sigEnable = 1'b0;
    total++;
    if (busy !== 1'b1 || overrun !== 1'b1 || error_I !== 11'sd40) begin
      bad++;
      $display("FAIL pre_reset busy=%b ovr=%b errI=%0d expected 1 1 40", busy, overrun, error_I);
    end
    #2 reset = 1'b1;
    #1;
    total++;
    if ({error_I, error_Q, busy, update_done, overrun, firCoefficient_I, firCoefficient_Q} !== '0) begin
      bad++;
      $display("FAIL async_reset err=(%0d,%0d) busy=%b done=%b ovr=%b expected all 0",
               error_I, error_Q, busy, update_done, overrun);
    end
    @(posedge clock);
    #1 reset = 1'b0;
    for (int c = 0; c < 5; c++) begin
      step();
      total++;
      if (update_done !== 1'b0 || busy !== 1'b0) begin
        bad++;
        $display("FAIL post_reset_idle cycle=%0d done=%b busy=%b expected 0 0", c, update_done, busy);
      end
    end
    ci = 0; cq = 0;
    for (int k = 0; k < 3; k++) begin
      ci = ci | int'(firCoefficient_I[k]);
      cq = cq | int'(firCoefficient_Q[k]);
    end
    total++;
    if (ci !== 0 || cq !== 0) begin
      bad++;
      $display("FAIL post_reset_coef orI=%0d orQ=%0d expected 0", ci, cq);
    end
  endtask

  // Strobe at cycle 0, walk to cycle 5 checking error at 1 and update_done at 4.
  task automatic run_update(input string name, input int exp_eI, input int exp_eQ,
                            input int eI[3], input int eQ[3]);
    sigEnable = 1'b1; adaptEnable = 1'b1;
    step();
    sigEnable = 1'b0;
    total++;
    if (error_I !== 11'(exp_eI) || error_Q !== 11'(exp_eQ) || busy !== 1'b1) begin
      bad++;
      $display("FAIL %s_error got=(%0d,%0d) busy=%b expected (%0d,%0d) busy=1",
               name, error_I, error_Q, busy, exp_eI, exp_eQ);
    end
    step(); step();
    total++;
    if (update_done !== 1'b0) begin
      bad++;
      $display("FAIL %s_early_done got=%b expected 0", name, update_done);
    end
    step();
    total++;
    if (update_done !== 1'b1 || busy !== 1'b1) begin
      bad++;
      $display("FAIL %s_done_c4 done=%b busy=%b expected 1 1", name, update_done, busy);
    end
    step();
    for (int k = 0; k < 3; k++) begin
      total++;
      if ($signed(firCoefficient_I[k]) !== 11'(eI[k]) || $signed(firCoefficient_Q[k]) !== 11'(eQ[k])) begin
        bad++;
        $display("FAIL %s_coef%0d got=(%0d,%0d) expected (%0d,%0d)", name, k,
                 $signed(firCoefficient_I[k]), $signed(firCoefficient_Q[k]), eI[k], eQ[k]);
      end
    end
    total++;
    if (busy !== 1'b0 || update_done !== 1'b0) begin
      bad++;
      $display("FAIL %s_idle busy=%b done=%b expected 0 0", name, busy, update_done);
    end
  endtask

  task automatic test_single_update();
    signal_I = 11'sd100; signal_Q = 0; desired_I = 11'sd40; desired_Q = 0;
    filtered_I = 0; filtered_Q = 0;
    step();
    run_update("single", 40, 0, '{0, 0, 1000}, '{0, 0, 0});
  endtask

  task automatic test_back_to_back();
    step();                       // strobe lands six cycles after the previous one
    run_update("repeat", 40, 0, '{0, 1000, 1023}, '{0, 0, 0});
  endtask

  task automatic test_error_sat();
    desired_I = 11'sd1000; desired_Q = -11'sd1000;
    filtered_I = -11'sd1000; filtered_Q = 11'sd1000;
    sigEnable = 1'b1; adaptEnable = 1'b0;
    step();
    sigEnable = 1'b0;
    total++;
    if (error_I !== 11'sd1023 || error_Q !== -11'sd1024) begin
      bad++;
      $display("FAIL err_sat got=(%0d,%0d) expected (1023,-1024)", error_I, error_Q);
    end
    for (int c = 0; c < 4; c++) begin
      total++;
      if (busy !== 1'b0) begin
        bad++;
        $display("FAIL err_sat_busy cycle=%0d got=%b expected 0", c, busy);
      end
      step();
    end
    total++;
    if ($signed(firCoefficient_I[2]) !== 11'sd1023 || $signed(firCoefficient_I[1]) !== 11'sd1000 ||
        firCoefficient_I[0] !== '0 || firCoefficient_Q !== '0) begin
      bad++;
      $display("FAIL err_sat_coef_kept c2=%0d c1=%0d expected 1023 1000",
               $signed(firCoefficient_I[2]), $signed(firCoefficient_I[1]));
    end
  endtask

  task automatic test_overrun();
    // history before strobe: I = {100,100,100}; after: {0,100,100}
    signal_I = 0; signal_Q = 0; desired_I = 11'sd40; desired_Q = 0;
    filtered_I = 0; filtered_Q = 0;
    sigEnable = 1'b1; adaptEnable = 1'b1;
    step();
    sigEnable = 1'b0;
    step();                       // cycle 2: second strobe with different data
    signal_I = 11'sd7; signal_Q = 11'sd7; desired_I = 11'sd5;
    sigEnable = 1'b1;
    step();
    sigEnable = 1'b0;
    total++;
    if (overrun !== 1'b1 || error_I !== 11'sd40 || error_Q !== 11'sd0) begin
      bad++;
      $display("FAIL overrun ovr=%b err=(%0d,%0d) expected 1 (40,0)", overrun, error_I, error_Q);
    end
    step();
    total++;
    if (update_done !== 1'b1) begin
      bad++;
      $display("FAIL overrun_done got=%b expected 1", update_done);
    end
    step();
    total++;
    if ($signed(firCoefficient_I[0]) !== 11'sd1000 || $signed(firCoefficient_I[1]) !== 11'sd1023 ||
        $signed(firCoefficient_I[2]) !== 11'sd1023 || overrun !== 1'b1) begin
      bad++;
      $display("FAIL overrun_coef got=(%0d,%0d,%0d) ovr=%b expected (1000,1023,1023) 1",
               $signed(firCoefficient_I[0]), $signed(firCoefficient_I[1]),
               $signed(firCoefficient_I[2]), overrun);
    end
  endtask

  task automatic test_complex_clear();
    // history I={0,100,100}, Q=0 -> after strobe I={0,0,100}, Q={41,0,0}; e=(0,-21)
    signal_I = 0; signal_Q = 11'sd41; desired_I = 0; desired_Q = -11'sd21;
    filtered_I = 0; filtered_Q = 0;
    step();
    run_update("complex", 0, -21, '{1000, 1023, 807}, '{525, 0, 0});
    sigEnable = 1'b1; adaptEnable = 1'b1;
    step();                       // cycle 1
    sigEnable = 1'b0;
    step();                       // cycle 2
    coefClear = 1'b1;
    #1;
    total++;
    if (update_done !== 1'b0) begin
      bad++;
      $display("FAIL clear_done_comb got=%b expected 0", update_done);
    end
    step();
    coefClear = 1'b0;
    total++;
    if (firCoefficient_I !== '0 || firCoefficient_Q !== '0 || busy !== 1'b0 || overrun !== 1'b0) begin
      bad++;
      $display("FAIL clear coefI=%h coefQ=%h busy=%b ovr=%b expected 0 0 0 0",
               firCoefficient_I, firCoefficient_Q, busy, overrun);
    end
    total++;
    if (error_I !== 11'sd0 || error_Q !== -11'sd21) begin
      bad++;
      $display("FAIL clear_err_kept got=(%0d,%0d) expected (0,-21)", error_I, error_Q);
    end
    for (int c = 0; c < 4; c++) begin
      step();
      total++;
      if (update_done !== 1'b0 || busy !== 1'b0) begin
        bad++;
        $display("FAIL clear_no_done cycle=%0d done=%b busy=%b expected 0 0", c, update_done, busy);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_update();
    test_back_to_back();
    test_error_sat();
    test_overrun();
    test_complex_clear();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
